// File: rtl/vpu_dst_port_pkg.sv
// Shared VPU definitions for the destination (store) port: geometry and FSM state type.
package vpu_dst_port_pkg;

    localparam int unsigned SRAM_DATA_WIDTH = 256;
    localparam int unsigned EXEC_CNT        = 2;
    localparam int unsigned EXEC_CNT_LG2    = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
    localparam int unsigned DWIDTH_PER_EXEC = SRAM_DATA_WIDTH / EXEC_CNT;
    localparam int unsigned SRAM_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } dst_state_e;

endpackage

// File: rtl/vpu_dst_port_controller.sv
// Store-operation FSM for the destination port: owns the target address and the
// single-word SRAM write handshake.
module vpu_dst_port_controller
    import vpu_dst_port_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              beat_last,
    input  logic              sram_ack,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              start_take,
    output logic              sram_req,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_wlast
);

    dst_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_take) begin
                addr_q <= waddr;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        start_take = 1'b0;
        ready      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        sram_req   = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start) begin
                    start_take = 1'b1;
                    state_d    = StCollect;
                end
            end
            StCollect: begin
                ready = 1'b1;
                if (beat_last) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Request is held until granted; ack outside this state is ignored.
                sram_req = 1'b1;
                if (sram_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign sram_web   = ~sram_req;
    assign sram_wlast = sram_req;
    assign sram_addr  = addr_q;

endmodule

// File: rtl/vpu_dst_port.sv
// VPU destination port: assembles EXEC_CNT VLANE result beats into one SRAM word
// and writes it to the address given with start_i.
module vpu_dst_port #(
    parameter int unsigned SRAM_DATA_WIDTH = vpu_dst_port_pkg::SRAM_DATA_WIDTH,
    parameter int unsigned EXEC_CNT        = vpu_dst_port_pkg::EXEC_CNT,
    parameter int unsigned DWIDTH_PER_EXEC = SRAM_DATA_WIDTH / EXEC_CNT,
    parameter int unsigned SRAM_ADDR_WIDTH = vpu_dst_port_pkg::SRAM_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [SRAM_ADDR_WIDTH-1:0] waddr_i,
    input  logic                       result_valid_i,
    input  logic [DWIDTH_PER_EXEC-1:0] result_i,
    output logic                       result_ready_o,
    output logic                       done_o,
    output logic                       busy_o,
    output logic                       sram_req_o,
    output logic                       sram_web_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [SRAM_DATA_WIDTH-1:0] sram_wdata_o,
    output logic                       sram_wlast_o,
    input  logic                       sram_ack_i
);

    localparam int unsigned CNT_W = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;

    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [SRAM_DATA_WIDTH-1:0] buf_q, buf_d;
    logic                       beat_fire;
    logic                       beat_last;
    logic                       start_take;

    assign beat_fire = result_valid_i & result_ready_o;
    assign beat_last = beat_fire && (cnt_q == CNT_W'(EXEC_CNT - 1));

    vpu_dst_port_controller #(
        .ADDR_W (SRAM_ADDR_WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_i),
        .waddr      (waddr_i),
        .beat_last  (beat_last),
        .sram_ack   (sram_ack_i),
        .ready      (result_ready_o),
        .busy       (busy_o),
        .done       (done_o),
        .start_take (start_take),
        .sram_req   (sram_req_o),
        .sram_web   (sram_web_o),
        .sram_addr  (sram_addr_o),
        .sram_wlast (sram_wlast_o)
    );

    // Beat 0 lands in the LSBs; the buffer only changes on an accepted beat.
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (start_take) begin
            cnt_d = '0;
        end else if (beat_fire) begin
            buf_d[int'(cnt_q) * DWIDTH_PER_EXEC +: DWIDTH_PER_EXEC] = result_i;
            cnt_d = beat_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

    assign sram_wdata_o = buf_q;

endmodule

// File: tb/tb_vpu_dst_port.sv
// Self-checking bench for vpu_dst_port: vector table of store operations plus
// hand-written sequences for reset abort and stray ack.
module tb_vpu_dst_port;

    localparam int unsigned DW  = 256;
    localparam int unsigned BW  = 128;
    localparam int unsigned AW  = 16;
    localparam int unsigned NEX = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [AW-1:0] waddr_i;
    logic          result_valid_i;
    logic [BW-1:0] result_i;
    logic          result_ready_o;
    logic          done_o;
    logic          busy_o;
    logic          sram_req_o;
    logic          sram_web_o;
    logic [AW-1:0] sram_addr_o;
    logic [DW-1:0] sram_wdata_o;
    logic          sram_wlast_o;
    logic          sram_ack_i;

    vpu_dst_port dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .waddr_i        (waddr_i),
        .result_valid_i (result_valid_i),
        .result_i       (result_i),
        .result_ready_o (result_ready_o),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .sram_req_o     (sram_req_o),
        .sram_web_o     (sram_web_o),
        .sram_addr_o    (sram_addr_o),
        .sram_wdata_o   (sram_wdata_o),
        .sram_wlast_o   (sram_wlast_o),
        .sram_ack_i     (sram_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] b0;
        logic [BW-1:0] b1;
        int            gap;
        int            ack_delay;
        bit            noise;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   done_exp = 0;
    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every granted write is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && done_o) done_seen++;
        if (rst_n && sram_req_o && sram_ack_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1'b1, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", sram_addr_o, e.addr);
                check("wr_data", sram_wdata_o, e.data);
                check("wr_wlast", sram_wlast_o, 1'b1);
                check("wr_web", sram_web_o, 1'b0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input vec_t v, input bit chk_lat);
        int  t0;
        wr_t w;
        w.addr = v.addr;
        w.data = {v.b1, v.b0};
        exp_q.push_back(w);
        done_exp++;
        t0 = cyc;
        start_i = 1'b1;
        waddr_i = v.addr;
        step();
        start_i = 1'b0;
        check("ready_collect", result_ready_o, 1'b1);
        check("busy_collect", busy_o, 1'b1);
        result_valid_i = 1'b1;
        result_i = v.b0;
        if (v.noise) begin
            start_i = 1'b1;
            waddr_i = 16'hFFFF;
        end
        step();
        start_i = 1'b0;
        result_valid_i = 1'b0;
        result_i = '1;
        for (int i = 0; i < v.gap; i++) begin
            check("ready_gap", result_ready_o, 1'b1);
            step();
        end
        result_valid_i = 1'b1;
        result_i = v.b1;
        step();
        result_valid_i = v.noise;
        result_i = ~v.b1;
        check("req_write", sram_req_o, 1'b1);
        check("ready_write", result_ready_o, 1'b0);
        for (int i = 0; i < v.ack_delay; i++) begin
            check("stall_req", sram_req_o, 1'b1);
            check("stall_addr", sram_addr_o, v.addr);
            check("stall_data", sram_wdata_o, {v.b1, v.b0});
            check("stall_done", done_o, 1'b0);
            step();
        end
        sram_ack_i = 1'b1;
        step();
        sram_ack_i = 1'b0;
        result_valid_i = 1'b0;
        check("done_pulse", done_o, 1'b1);
        check("req_done", sram_req_o, 1'b0);
        if (chk_lat) check("latency", cyc - t0, NEX + 2);
        if (v.noise) start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("done_once", done_o, 1'b0);
        check("idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        vecs[0] = '{16'h0010, {32{4'hA}}, {32{4'h5}}, 0, 0, 1'b0};
        vecs[1] = '{16'h1234, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
                    128'h8899_AABB_CCDD_EEFF_FEDC_BA98_7654_3210, 0, 7, 1'b0};
        vecs[2] = '{16'hBEEF, 128'hDEAD_BEEF, 128'hCAFE_F00D, 3, 1, 1'b0};
        vecs[3] = '{16'h0042, {4{32'h1357_9BDF}}, {4{32'h2468_ACE0}}, 1, 2, 1'b1};
        vecs[4] = '{16'hFFFE, '1, '0, 0, 0, 1'b0};

        rst_n = 1'b0;
        start_i = 1'b0;
        waddr_i = '0;
        result_valid_i = 1'b0;
        result_i = '0;
        sram_ack_i = 1'b0;
        step();
        step();
        check("rst_req", sram_req_o, 1'b0);
        check("rst_web", sram_web_o, 1'b1);
        check("rst_addr", sram_addr_o, '0);
        check("rst_wdata", sram_wdata_o, '0);
        check("rst_wlast", sram_wlast_o, 1'b0);
        check("rst_ready", result_ready_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_n = 1'b1;
        step();

        // Stray ack in idle must not move the FSM.
        sram_ack_i = 1'b1;
        step();
        sram_ack_i = 1'b0;
        check("idle_ack_busy", busy_o, 1'b0);
        check("idle_ack_done", done_o, 1'b0);
        check("idle_ack_req", sram_req_o, 1'b0);

        // Valid in idle must not touch the buffer.
        result_valid_i = 1'b1;
        result_i = '1;
        step();
        result_valid_i = 1'b0;
        check("idle_valid_buf", sram_wdata_o, '0);

        for (int i = 0; i < 5; i++) run_op(vecs[i], (vecs[i].gap == 0 && vecs[i].ack_delay == 0));

        // Reset while in WRITE aborts without a done pulse.
        start_i = 1'b1;
        waddr_i = 16'h0777;
        step();
        start_i = 1'b0;
        result_valid_i = 1'b1;
        result_i = 128'h1111;
        step();
        result_i = 128'h2222;
        step();
        result_valid_i = 1'b0;
        check("abort_req_before", sram_req_o, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_req", sram_req_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_wdata", sram_wdata_o, '0);
        check("abort_addr", sram_addr_o, '0);
        step();
        check("abort_no_done", done_o, 1'b0);

        run_op(vecs[0], 1'b1);

        repeat (3) step();
        check("sb_empty", exp_q.size(), 0);
        check("done_count", done_seen, done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
